// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_pkg
//  Description : Shared constants and the sequencer state type for the
//                zig-zag reorder stage.
//  Revision    : 1.0
// ============================================================================
package jpeg_pkg;

    localparam int ROWS_PER_BLOCK = 8;
    localparam int ROW_IDX_W      = $clog2(ROWS_PER_BLOCK);
    localparam int INIT_CYCLES    = 2;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/zz_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module      : zz_tag_delay
//  Description : Shift register that lines the valid/row tags up with the
//                reorder buffer's registered output.
//  Revision    : 1.0
// ============================================================================
module zz_tag_delay
    import jpeg_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RW    = ROW_IDX_W
) (
    input  logic          i_clk,
    input  logic          i_Reset,
    input  logic          i_valid,
    input  logic [RW-1:0] i_row,
    output logic          o_valid,
    output logic [RW-1:0] o_row,
    output logic          o_last,
    output logic          o_last_next
);

    localparam logic [RW-1:0] c_LAST_ROW = RW'(ROWS_PER_BLOCK - 1);

    logic [DEPTH-1:0] r_valid;
    logic [RW-1:0]    r_row [DEPTH];

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_row[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_row[0]   <= i_row;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_row[i]   <= r_row[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_row   = r_row[DEPTH-1];
    assign o_last  = r_valid[DEPTH-1] && (r_row[DEPTH-1] == c_LAST_ROW);

    // Lets a consumer register a value that changes in the same cycle o_last rises.
    generate
        if (DEPTH >= 2) begin : g_last_next_pipe
            assign o_last_next = r_valid[DEPTH-2] && (r_row[DEPTH-2] == c_LAST_ROW);
        end else begin : g_last_next_in
            assign o_last_next = i_valid && (i_row == c_LAST_ROW);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/zigzag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_ctrl
//  Description : Load/drain sequencer and output tagger for the 8x8 zig-zag
//                reorder buffer.
//  Revision    : 1.0
// ============================================================================
module zigzag_ctrl
    import jpeg_pkg::*;
#(
    parameter int BW               = 8,
    parameter int BLOCKS_PER_FRAME = 4,
    parameter int BCW              = 16
) (
    input  logic                 i_clk,
    input  logic                 i_Reset,
    input  logic [8*BW-1:0]      i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_ds_ready,
    output logic [8*BW-1:0]      o_zz_data,
    output logic                 o_zz_enable,
    output logic                 o_out_valid,
    output logic [ROW_IDX_W-1:0] o_out_row,
    output logic                 o_out_last,
    output logic                 o_frame_done,
    output logic [BCW-1:0]       o_block_cnt,
    output logic                 o_busy
);

    localparam int                   RW          = ROW_IDX_W;
    localparam logic [RW-1:0]        c_LAST_ROW  = RW'(ROWS_PER_BLOCK - 1);
    localparam logic [1:0]           c_INIT_LAST = 2'(INIT_CYCLES - 1);
    localparam logic [BCW-1:0]       c_LAST_BLK  = BCW'(BLOCKS_PER_FRAME - 1);

    state_t          r_state;
    logic [1:0]      r_init_cnt;
    logic [RW-1:0]   r_rows;
    logic [RW-1:0]   r_drain;
    logic [8*BW-1:0] r_zz_data;
    logic            r_zz_en;
    logic            r_busy;
    logic [BCW-1:0]  r_block_cnt;
    logic            r_frame_done;

    logic            w_ready;
    logic            w_hs;
    logic            w_last_next;

    // The 8th row is only taken when the downstream can absorb the whole drain.
    assign w_ready = (r_state == LOAD) && ((r_rows != c_LAST_ROW) || i_ds_ready);
    assign w_hs    = i_valid && w_ready;

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_rows     <= '0;
            r_drain    <= '0;
            r_zz_data  <= '0;
            r_zz_en    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_zz_en <= 1'b0;
            case (r_state)
                INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_zz_data <= i_data;
                        r_zz_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        if (r_rows == c_LAST_ROW) begin
                            r_state <= DRAIN;
                            r_rows  <= '0;
                            r_drain <= '0;
                        end else begin
                            r_rows <= r_rows + 1'b1;
                        end
                    end else begin
                        r_busy <= (r_rows != '0);
                    end
                end
                DRAIN: begin
                    if (r_drain == c_LAST_ROW) begin
                        r_state <= LOAD;
                        r_drain <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Drain cycle k appears on the buffer output two edges later.
    zz_tag_delay #(
        .DEPTH (2),
        .RW    (RW)
    ) u_tag_delay (
        .i_clk       (i_clk),
        .i_Reset     (i_Reset),
        .i_valid     (r_state == DRAIN),
        .i_row       (r_drain),
        .o_valid     (o_out_valid),
        .o_row       (o_out_row),
        .o_last      (o_out_last),
        .o_last_next (w_last_next)
    );

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_block_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_last_next) begin
                if (r_block_cnt == c_LAST_BLK) begin
                    r_block_cnt  <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_block_cnt <= r_block_cnt + 1'b1;
                end
            end
        end
    end

    assign o_ready      = w_ready;
    assign o_zz_data    = r_zz_data;
    assign o_zz_enable  = r_zz_en;
    assign o_busy       = r_busy;
    assign o_block_cnt  = r_block_cnt;
    assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/zigzag_ctrl.md
Name: zigzag_ctrl

Overview:
- Sequencer in front of the 8x8 zig-zag reorder buffer in the JPEG pipeline.
- Accepts quantized rows from upstream over a valid/ready handshake and drives the buffer's enable and row data.
- Blocks upstream while the buffer drains, since the drain cannot be stalled.
- Generates row-index, last and frame tags that line up cycle-exactly with the buffer's o_data, for the entropy coder.

Parameters:
- BW, 8, bits per coefficient (a row is 8*BW bits).
- BLOCKS_PER_FRAME, 4, 8x8 blocks per frame, at least 1.
- BCW, 16, width of the block counter.

Ports:
- i_clk  in  1  clock.
- i_Reset  in  1  asynchronous active-low reset; also drives the buffer's reset.
- i_data  in  8*BW  upstream row.
- i_valid  in  1  upstream row valid.
- o_ready  out  1  controller can accept a row this cycle.
- i_ds_ready  in  1  downstream can absorb a full 8-row burst.
- o_zz_data  out  8*BW  registered row to the buffer's i_data.
- o_zz_enable  out  1  registered load strobe to the buffer's i_enable.
- o_out_valid  out  1  buffer o_data holds a valid zig-zag row this cycle.
- o_out_row  out  3  index of the row currently on buffer o_data (0..7).
- o_out_last  out  1  high with o_out_row==7.
- o_frame_done  out  1  high with o_out_last of the final block of a frame.
- o_block_cnt  out  BCW  blocks completed in the current frame.
- o_busy  out  1  state is not LOAD-with-zero-rows.

Behaviour:
- Reset (asynchronous, active-low): every output is 0, state INIT, row counter 0, block counter 0.
- Buffer contract:
  - Each enabled edge writes one row.
  - The edge after the 8th write starts an 8-cycle drain that cannot be stalled.
  - Drain row k appears on buffer o_data one registered cycle after drain cycle k.
  - Any enable sampled during the drain, or at the drain's terminal edge, corrupts the block.
  - The buffer spends its first clocked cycle after reset release in the terminal drain slot.
- States:
  - INIT: o_ready=0 for 2 cycles after reset release, then go to LOAD.
  - LOAD: track rows accepted, 0..7.
    - o_ready=1 while rows<7.
    - When rows==7, o_ready=i_ds_ready.
    - Handshake is i_valid & o_ready at an edge.
    - On handshake: o_zz_data<=i_data, o_zz_enable<=1 for exactly one cycle, row count +1.
    - No handshake: o_zz_enable<=0 and o_zz_data holds.
    - Acceptance of the 8th row (edge A) goes to DRAIN.
  - DRAIN: o_ready=0 for 8 cycles (edges A+1..A+8), then return to LOAD with rows=0.
    - Earliest next acceptance is edge A+9, so the buffer's next write lands at A+10.
    - Minimum block period is 16 cycles.
- Output tagging:
  - A delay pipeline sets o_out_valid=1 during the cycles following edges A+2..A+9.
  - o_out_row counts 0..7 over those cycles; o_out_last is high on row 7.
  - o_out_valid is never high outside those 8 cycles.
- Block/frame counting:
  - o_block_cnt increments on the cycle o_out_last is high.
  - When the count reaches BLOCKS_PER_FRAME-1, o_frame_done is high together with o_out_last and o_block_cnt wraps to 0.
- Upstream stalls in LOAD (i_valid low) are unlimited; the buffer holds its load position.
- i_ds_ready is sampled only for the 8th row. Once the 8th row is accepted, the downstream must take all 8 rows; the controller does not re-check.
- i_ds_ready low with rows==7: hold, o_ready=0, no enable.
- Reset asserted mid-block: the block is discarded, all tags drop immediately, and the sequence restarts at INIT.

Decomposition:
- Shared package jpeg_pkg: ROWS_PER_BLOCK=8 and the state enum (INIT, LOAD, DRAIN).
- One natural sub-module, zz_tag_delay: shift register that aligns the valid/row/last tags with the buffer output.

Test Plan:
- Reset release with i_valid held 1 -> o_ready=0 for 2 cycles, then 1; first o_zz_enable appears the cycle after the first acceptance.
- 8 back-to-back rows 0x0101..0x0808 with i_ds_ready=1 -> o_zz_enable high 8 cycles; o_ready low edges A+1..A+8; o_out_valid high 8 cycles starting after A+2; o_out_row 0..7; o_out_last on row 7.
- i_ds_ready=0 at the 8th row for 5 cycles -> o_ready=0 and no enable for those cycles; accept on the cycle i_ds_ready rises; drain timing is relative to that edge.
- Two blocks streamed continuously -> second block's first enable exactly 10 cycles after the first block's last acceptance edge; period 16.
- BLOCKS_PER_FRAME=4, 5 blocks -> o_frame_done once, on block 4's last row; o_block_cnt sequence 1,2,3,0,1.
- Reset asserted during drain row 3 -> all outputs 0 asynchronously; after release, INIT then LOAD, with no stray o_out_valid.
